// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline hazard controller.
//   - Forwarding select encodings driven on fwd_a / fwd_b.
//   - WDSel encodings from the ID-stage decoder (2'b01 marks a load).
//   - Controller FSM states.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from MEM/WB
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX/MEM

  localparam logic [1:0] WDSel_FromALU = 2'b00;
  localparam logic [1:0] WDSel_FromMEM = 2'b01;
  localparam logic [1:0] WDSel_FromPC  = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
//   master : datapath side (drives ID decode, redirect, dm_ready; receives controls)
//   slave  : controller side (receives decode/handshake; drives stalls, flushes, fwd)
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5
) ();

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_RegWrite;
  logic [1:0]        id_WDSel;
  logic              id_MemWrite;
  logic              ex_redirect;
  logic              dm_ready;
  logic              dm_req;
  logic              stall_pc;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              freeze_ex_mem;
  logic              freeze_mem_wb;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_RegWrite, id_WDSel, id_MemWrite, ex_redirect, dm_ready,
    input  dm_req, stall_pc, stall_if_id, flush_if_id, flush_id_ex,
           freeze_ex_mem, freeze_mem_wb, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_RegWrite, id_WDSel, id_MemWrite, ex_redirect, dm_ready,
    output dm_req, stall_pc, stall_if_id, flush_if_id, flush_id_ex,
           freeze_ex_mem, freeze_mem_wb, fwd_a, fwd_b
  );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding comparator for one EX operand.
//   use_rs_i/rs_i          : EX operand is read / its source index
//   mem_*_i                : EX/MEM occupant (valid, RegWrite, is_load, rd)
//   wb_*_i                 : MEM/WB occupant (valid, RegWrite, rd)
//   fwd_o                  : FWD_MEM, FWD_WB or FWD_RF
module hazard_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              use_rs_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic              mem_valid_i,
  input  logic              mem_regwrite_i,
  input  logic              mem_is_load_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_valid_i,
  input  logic              wb_regwrite_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output logic [1:0]        fwd_o
);

  logic mem_hit_s;
  logic wb_hit_s;

  // Youngest producer wins; a load in EX/MEM has no data yet and x0 never forwards.
  always_comb begin
    mem_hit_s = use_rs_i & mem_valid_i & mem_regwrite_i & ~mem_is_load_i &
                (mem_rd_i != {REG_AW{1'b0}}) & (mem_rd_i == rs_i);
    wb_hit_s  = use_rs_i & wb_valid_i & wb_regwrite_i &
                (wb_rd_i != {REG_AW{1'b0}}) & (wb_rd_i == rs_i);
    if (mem_hit_s) begin
      fwd_o = FWD_MEM;
    end else if (wb_hit_s) begin
      fwd_o = FWD_WB;
    end else begin
      fwd_o = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall / flush / freeze sequencing and EX forwarding for a 5-stage RV32I pipe.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : ID decode, ex_redirect, dm_ready in; pipeline controls out
//   cnt_*         : wrapping hazard counters (load-use, redirect, memory wait)
// Shadow trackers mirror the ID/EX, EX/MEM and MEM/WB registers so every
// decision uses the same occupancy the datapath sees.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]   cnt_load_use,
  output logic [CNT_W-1:0]   cnt_redirect,
  output logic [CNT_W-1:0]   cnt_mem_wait
);

  // EX slot
  logic              ex_valid_q, ex_regwrite_q, ex_is_load_q, ex_is_mem_q;
  logic              ex_use_rs1_q, ex_use_rs2_q;
  logic [REG_AW-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  // MEM slot
  logic              mem_valid_q, mem_regwrite_q, mem_is_load_q, mem_is_mem_q;
  logic [REG_AW-1:0] mem_rd_q;
  // WB slot
  logic              wb_valid_q, wb_regwrite_q;
  logic [REG_AW-1:0] wb_rd_q;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_load_use_q, cnt_redirect_q, cnt_mem_wait_q;

  logic              dm_req_s, mem_hold_s, redirect_s, load_use_s, ex_load_hit_s;
  logic              id_is_load_s;
  logic [1:0]        fwd_a_s, fwd_b_s;

  // Hazard classification, in priority order: memory hold, redirect, load-use.
  always_comb begin
    id_is_load_s  = (bus.id_WDSel == WDSel_FromMEM);
    dm_req_s      = mem_valid_q & mem_is_mem_q;
    mem_hold_s    = dm_req_s & ~bus.dm_ready;
    redirect_s    = bus.ex_redirect & ~mem_hold_s;
    ex_load_hit_s = ex_valid_q & ex_is_load_q & ex_regwrite_q &
                    (ex_rd_q != {REG_AW{1'b0}}) &
                    ((bus.id_use_rs1 & (bus.id_rs1 == ex_rd_q)) |
                     (bus.id_use_rs2 & (bus.id_rs2 == ex_rd_q)));
    load_use_s    = ~mem_hold_s & ~bus.ex_redirect & bus.id_valid & ex_load_hit_s;
  end

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .use_rs_i(ex_use_rs1_q), .rs_i(ex_rs1_q),
    .mem_valid_i(mem_valid_q), .mem_regwrite_i(mem_regwrite_q),
    .mem_is_load_i(mem_is_load_q), .mem_rd_i(mem_rd_q),
    .wb_valid_i(wb_valid_q), .wb_regwrite_i(wb_regwrite_q), .wb_rd_i(wb_rd_q),
    .fwd_o(fwd_a_s)
  );

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .use_rs_i(ex_use_rs2_q), .rs_i(ex_rs2_q),
    .mem_valid_i(mem_valid_q), .mem_regwrite_i(mem_regwrite_q),
    .mem_is_load_i(mem_is_load_q), .mem_rd_i(mem_rd_q),
    .wb_valid_i(wb_valid_q), .wb_regwrite_i(wb_regwrite_q), .wb_rd_i(wb_rd_q),
    .fwd_o(fwd_b_s)
  );

  // Pipeline controls; all forced quiet while reset is asserted.
  always_comb begin
    bus.stall_pc      = 1'b0;
    bus.stall_if_id   = 1'b0;
    bus.flush_if_id   = 1'b0;
    bus.flush_id_ex   = 1'b0;
    bus.freeze_ex_mem = 1'b0;
    bus.freeze_mem_wb = 1'b0;
    bus.fwd_a         = FWD_RF;
    bus.fwd_b         = FWD_RF;
    if (rst) begin
      bus.stall_pc = 1'b0;
    end else begin
      bus.stall_pc      = mem_hold_s | load_use_s;
      bus.stall_if_id   = mem_hold_s | load_use_s;
      bus.flush_if_id   = redirect_s;
      bus.flush_id_ex   = redirect_s | load_use_s;
      bus.freeze_ex_mem = mem_hold_s;
      bus.freeze_mem_wb = mem_hold_s;
      bus.fwd_a         = fwd_a_s;
      bus.fwd_b         = fwd_b_s;
    end
  end

  assign bus.dm_req   = dm_req_s;
  assign cnt_load_use = cnt_load_use_q;
  assign cnt_redirect = cnt_redirect_q;
  assign cnt_mem_wait = cnt_mem_wait_q;

  // Shadow trackers advance with the datapath registers they mirror.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;  ex_regwrite_q <= 1'b0;  ex_is_load_q <= 1'b0;
      ex_is_mem_q    <= 1'b0;  ex_use_rs1_q  <= 1'b0;  ex_use_rs2_q <= 1'b0;
      ex_rd_q        <= {REG_AW{1'b0}};
      ex_rs1_q       <= {REG_AW{1'b0}};
      ex_rs2_q       <= {REG_AW{1'b0}};
      mem_valid_q    <= 1'b0;  mem_regwrite_q <= 1'b0;
      mem_is_load_q  <= 1'b0;  mem_is_mem_q   <= 1'b0;
      mem_rd_q       <= {REG_AW{1'b0}};
      wb_valid_q     <= 1'b0;  wb_regwrite_q  <= 1'b0;
      wb_rd_q        <= {REG_AW{1'b0}};
    end else if (!mem_hold_s) begin
      wb_valid_q     <= mem_valid_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_rd_q        <= mem_rd_q;
      mem_valid_q    <= ex_valid_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_is_load_q  <= ex_is_load_q;
      mem_is_mem_q   <= ex_is_mem_q;
      mem_rd_q       <= ex_rd_q;
      if (redirect_s || load_use_s) begin
        // Bubble carries no register use so it can never trigger forwarding.
        ex_valid_q    <= 1'b0;  ex_regwrite_q <= 1'b0;  ex_is_load_q <= 1'b0;
        ex_is_mem_q   <= 1'b0;  ex_use_rs1_q  <= 1'b0;  ex_use_rs2_q <= 1'b0;
        ex_rd_q       <= {REG_AW{1'b0}};
        ex_rs1_q      <= {REG_AW{1'b0}};
        ex_rs2_q      <= {REG_AW{1'b0}};
      end else begin
        ex_valid_q    <= bus.id_valid;
        ex_regwrite_q <= bus.id_valid & bus.id_RegWrite;
        ex_is_load_q  <= bus.id_valid & id_is_load_s;
        ex_is_mem_q   <= bus.id_valid & (id_is_load_s | bus.id_MemWrite);
        ex_use_rs1_q  <= bus.id_valid & bus.id_use_rs1;
        ex_use_rs2_q  <= bus.id_valid & bus.id_use_rs2;
        ex_rd_q       <= bus.id_rd;
        ex_rs1_q      <= bus.id_rs1;
        ex_rs2_q      <= bus.id_rs2;
      end
    end
  end

  // RUN / MEM_WAIT sequencing of data-memory handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:      if (dm_req_s && !bus.dm_ready) state_q <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (bus.dm_ready) state_q <= ST_RUN;
        default:     state_q <= ST_RUN;
      endcase
    end
  end

  // Hazard performance counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_load_use_q <= {CNT_W{1'b0}};
      cnt_redirect_q <= {CNT_W{1'b0}};
      cnt_mem_wait_q <= {CNT_W{1'b0}};
    end else begin
      if (load_use_s) cnt_load_use_q <= cnt_load_use_q + CNT_W'(1);
      if (redirect_s) cnt_redirect_q <= cnt_redirect_q + CNT_W'(1);
      if (mem_hold_s) cnt_mem_wait_q <= cnt_mem_wait_q + CNT_W'(1);
    end
  end

endmodule
